// File: rtl/fir_inverse_sfir.sv
// Inverse of the 4-tap saturating FIR: rebuilds x[n] from y[n] using one shared
// saturating multiplier over a three-step MAC sequence with valid/ready on both sides.
module fir_inverse_sfir #(
   parameter int COEF0  = 2,
   parameter int COEF1  = 3,
   parameter int COEF2  = -2,
   parameter int COEF3  = 8,
   parameter int SHIFT0 = 1
) (
   input  logic                system1000,
   input  logic                system1000_rstn,
   input  logic signed [15:0]  y_t,
   input  logic                in_valid,
   output logic                in_ready,
   output logic signed [15:0]  x_hat,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int unsigned W  = 16;
   localparam int unsigned PW = 32;
   // Division by c0 is a shift; SHIFT0 is trusted unless it disagrees with COEF0.
   localparam int unsigned SH =
      unsigned'((COEF0 == (1 << SHIFT0)) ? SHIFT0 : $clog2(COEF0));

   localparam logic signed [W-1:0] C1 = W'(COEF1);
   localparam logic signed [W-1:0] C2 = W'(COEF2);
   localparam logic signed [W-1:0] C3 = W'(COEF3);

   localparam logic signed [PW-1:0] MAXV = 32'sd32767;
   localparam logic signed [PW-1:0] MINV = -32'sd32768;

   typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, OUT} state_t;

   state_t state_q, state_d;

   logic signed [W-1:0]  acc_q, acc_d;
   logic signed [W-1:0]  h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
   logic signed [W-1:0]  x_hat_q, x_hat_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;

   logic signed [W-1:0]  mul_a, mul_b;
   logic signed [PW-1:0] prod, diff;
   logic signed [W-1:0]  prod_sat, diff_sat, x_new;

   function automatic logic signed [W-1:0] sat16(input logic signed [PW-1:0] v);
      if (v > MAXV)      sat16 = W'(MAXV);
      else if (v < MINV) sat16 = W'(MINV);
      else               sat16 = W'(v);
   endfunction

   // Shared multiplier: coefficient/history pair chosen by the current MAC step.
   always_comb begin
      mul_a = C1;
      mul_b = h0_q;
      case (state_q)
         MAC2: begin
            mul_a = C2;
            mul_b = h1_q;
         end
         MAC3: begin
            mul_a = C3;
            mul_b = h2_q;
         end
         default: ;
      endcase
      prod     = PW'(mul_a) * PW'(mul_b);
      prod_sat = sat16(prod);
      diff     = PW'(acc_q) - PW'(prod_sat);
      diff_sat = sat16(diff);
      x_new    = diff_sat >>> SH;
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      h0_d        = h0_q;
      h1_d        = h1_q;
      h2_d        = h2_q;
      x_hat_d     = x_hat_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               acc_d      = y_t;
               in_ready_d = 1'b0;
               state_d    = MAC1;
            end
         end
         MAC1: begin
            acc_d   = diff_sat;
            state_d = MAC2;
         end
         MAC2: begin
            acc_d   = diff_sat;
            state_d = MAC3;
         end
         MAC3: begin
            x_hat_d     = x_new;
            out_valid_d = 1'b1;
            h2_d        = h1_q;
            h1_d        = h0_q;
            h0_d        = x_new;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) state_q <= IDLE;
      else                  state_q <= state_d;
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         acc_q       <= '0;
         h0_q        <= '0;
         h1_q        <= '0;
         h2_q        <= '0;
         x_hat_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         acc_q       <= acc_d;
         h0_q        <= h0_d;
         h1_q        <= h1_d;
         h2_q        <= h2_d;
         x_hat_q     <= x_hat_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign x_hat     = x_hat_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_inverse_sfir.sv
// Scoreboard bench for fir_inverse_sfir: directed and random y streams checked
// against an integer deconvolution model, plus latency, backpressure and reset checks.
module tb_fir_inverse_sfir;

   localparam int C1 = 3;
   localparam int C2 = -2;
   localparam int C3 = 8;
   localparam int SHIFT = 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [15:0] y_t;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] x_hat;
   logic               out_valid;
   logic               out_ready;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int hist[3];
   int exp_q[$];
   int lat_q[$];
   bit hold = 1'b0;
   bit rnd_rdy = 1'b0;
   bit prev_ov = 1'b0;

   fir_inverse_sfir dut (
      .system1000      (clk),
      .system1000_rstn (rst_n),
      .y_t             (y_t),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .x_hat           (x_hat),
      .out_valid       (out_valid),
      .out_ready       (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Deconvolution model: x = (y - c1*x1 - c2*x2 - c3*x3) / c0, each step clamped.
   function automatic int model(input int y);
      int acc;
      int x;
      acc = y;
      acc = sat(acc - sat(C1 * hist[0]));
      acc = sat(acc - sat(C2 * hist[1]));
      acc = sat(acc - sat(C3 * hist[2]));
      x = acc >>> SHIFT;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = x;
      return x;
   endfunction

   // Downstream ready: held low, random, or always high.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = hold ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Acceptance observer: the coming edge consumes y_t, so push its expected result.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         exp_q.push_back(model(int'(y_t)));
         lat_q.push_back(cyc + 1);
      end
   end

   // Output monitor: latency on each new output, value on each handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (lat_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out_valid: got out_valid=1, expected no pending sample");
            end else begin
               chk("out_latency", cyc, lat_q.pop_front() + 3);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got x_hat=%0d, expected none", x_hat);
            end else begin
               chk("x_hat", int'(x_hat), exp_q.pop_front());
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic present(input int y);
      y_t = 16'(y);
      in_valid = 1'b1;
   endtask

   task automatic wait_accept();
      int n = 0;
      bit hs = 1'b0;
      while (!hs && n < 60) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!hs) chk("accept_timeout", 0, 1);
   endtask

   task automatic send(input int y);
      present(y);
      wait_accept();
   endtask

   task automatic wait_idle();
      int n = 0;
      bit done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !out_valid && in_ready;
         n++;
      end
      @(posedge clk);
      #1;
      if (!done) chk("drain_timeout", 0, 1);
   endtask

   // Asynchronous reset: outputs must return to reset values before any edge.
   task automatic apply_reset(input string nm);
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk({nm, "_out_valid"}, int'(out_valid), 0);
      chk({nm, "_x_hat"}, int'(x_hat), 0);
      chk({nm, "_in_ready"}, int'(in_ready), 1);
      hist = '{0, 0, 0};
      exp_q.delete();
      lat_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int impulse[6] = '{2, 3, -2, 8, 0, 0};
      int two[3] = '{200, 200, -350};
      int y;
      int n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      y_t = '0;
      hist = '{0, 0, 0};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_x_hat", int'(x_hat), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (impulse[i]) send(impulse[i]);
      wait_idle();
      foreach (two[i]) send(two[i]);
      wait_idle();

      apply_reset("rst_a");
      send(32767);
      send(-32768);
      wait_idle();
      apply_reset("rst_b");
      send(-3);
      wait_idle();
      apply_reset("rst_c");
      send(-32768);
      wait_idle();

      // Backpressure: output held, pending input must not be consumed.
      hold = 1'b1;
      send(500);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("bp_wait_timeout", 0, 1);
      @(posedge clk);
      #1;
      present(-700);
      repeat (10) begin
         @(negedge clk);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_in_ready", int'(in_ready), 0);
         if (exp_q.size() > 0) chk("bp_x_hat_stable", int'(x_hat), exp_q[0]);
      end
      @(posedge clk);
      #1;
      hold = 1'b0;
      wait_accept();
      wait_idle();

      // Reset while in MAC2 discards the partial sample and history.
      send(1234);
      @(posedge clk);
      #1;
      apply_reset("rst_mac2");
      foreach (impulse[i]) if (i < 4) send(impulse[i]);
      wait_idle();

      // Random stream with random gaps and random downstream ready.
      rnd_rdy = 1'b1;
      for (int k = 0; k < 150; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         case ($urandom_range(0, 3))
            0:       y = int'($urandom_range(0, 65535)) - 32768;
            1, 2:    y = int'($urandom_range(0, 1000)) - 500;
            default: begin
               case ($urandom_range(0, 3))
                  0:       y = 32767;
                  1:       y = -32768;
                  2:       y = -1;
                  default: y = 0;
               endcase
            end
         endcase
         send(y);
      end
      rnd_rdy = 1'b0;
      wait_idle();
      chk("final_exp_q_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fir_inverse_sfir.md
Name: fir_inverse_sfir

Overview:
- Sequential inverse (deconvolution) filter for the 4-tap saturating FIR in the FIR block family.
- Takes the FIR output stream y[n] and reconstructs x[n] = (y[n] − c1·x[n−1] − c2·x[n−2] − c3·x[n−3]) / c0.
- Sits at the receiving end of an FIR-filtered sample link.
- Uses valid/ready handshakes on both sides.
- Uses one time-shared saturating multiplier over a multi-cycle MAC sequence.

Parameters:
- COEF0, 2, tap 0 coefficient; must equal 2**SHIFT0.
- COEF1, 3, tap 1 coefficient (applied to x[n−1]), signed 16.
- COEF2, -2, tap 2 coefficient (applied to x[n−2]), signed 16.
- COEF3, 8, tap 3 coefficient (applied to x[n−3]), signed 16.
- SHIFT0, 1, log2(COEF0); division by c0 is an arithmetic right shift by SHIFT0.

Ports:
- system1000  in  1  clock, rising edge.
- system1000_rstn  in  1  asynchronous reset, active low.
- y_t  in  16 signed  FIR output sample.
- in_valid  in  1  y_t valid.
- in_ready  out  1  block can accept y_t.
- x_hat  out  16 signed  reconstructed sample.
- out_valid  out  1  x_hat valid.
- out_ready  in  1  downstream accepts x_hat.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, acc=0, history h0=h1=h2=0.
  - x_hat=0, out_valid=0, in_ready=1.
- Arithmetic: all signed 16-bit.
  - satMul: full product clamped to [−32768, 32767].
  - satSub: difference clamped to the same range.
  - Division: arithmetic shift right by SHIFT0 (rounds toward −inf).
- FSM states: IDLE, MAC1, MAC2, MAC3, OUT.
- IDLE:
  - in_ready=1.
  - On edge with in_valid&&in_ready: acc<=y_t, go to MAC1.
- MAC1: acc<=satSub(acc, satMul(COEF1,h0)), go to MAC2.
- MAC2: acc<=satSub(acc, satMul(COEF2,h1)), go to MAC3.
- MAC3:
  - r=satSub(acc, satMul(COEF3,h2)).
  - x_hat<=r>>>SHIFT0, out_valid<=1.
  - History shift: h2<=h1, h1<=h0, h0<=r>>>SHIFT0.
  - Go to OUT.
- OUT:
  - out_valid=1; x_hat held stable.
  - On out_ready: out_valid<=0, go to IDLE.
- in_ready is 1 only in IDLE. Input accepted on edge T gives out_valid=1 from edge T+3.
- Minimum initiation interval: 5 cycles (accept edge, 3 MAC edges, output handshake edge).
- History updates exactly once per accepted sample, at the MAC3 edge. Backpressure never alters history.
- out_ready asserted while not in OUT is ignored. in_valid outside IDLE is ignored (not consumed).
- Reset asserted mid-operation: immediate return to reset values. The partial sample and all history are discarded.
- Saturation is sticky per step only. A saturated intermediate is used as-is for the following step; no overflow flag.

Test Plan:
- Impulse: reset, then send y=2,3,−2,8,0,0 with out_ready=1 -> x_hat=1,0,0,0,0,0; each out_valid exactly 3 cycles after its accept edge.
- Two-sample sequence: y=200,200 -> x_hat=100,−50. Then y=−350 (=2·0+3·(−50)+(−2)·100) -> x_hat=0.
- Rounding/saturation, history=0:
  - y=32767 -> x_hat=16383.
  - y=−3 -> x_hat=−2.
  - y=−32768 -> x_hat=−16384.
- Saturating product: preload history h0=20000 (send y=−25536 decodes... use direct y=32767 then 32767 path) -> satMul(3,16383) clamps at 32767 only when operand >10922.
  - Check y=−32768 after h0=16383: satSub(−32768, 32767) clamps to −32768 -> x_hat=−16384.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> x_hat and out_valid stable, in_ready=0, a pending in_valid is not consumed; release -> pending sample accepted on the next IDLE edge.
- Reset mid-MAC2: assert system1000_rstn=0 -> out_valid=0, x_hat=0, in_ready=1 asynchronously; after release, impulse test again yields 1,0,0,0 (history cleared).
